// File: rtl/ram_16x8.sv
// ram_16x8: 16-word x 8-bit program/data memory for SAP-1.
// Responds to MAR reads in run mode with a registered byte for the W bus,
// accepts a sequential program load over a valid/ready handshake, and
// clears every word to INIT_VALUE with a 16-cycle sweep after reset.
module ram_16x8 #(
  parameter int                ADDR_W     = 4,
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] INIT_VALUE = 8'h00
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              PROG,
  input  logic              CE_bar,
  input  logic [ADDR_W-1:0] mar_input,
  output logic [DATA_W-1:0] ram_output,
  output logic              ram_oe,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic [ADDR_W-1:0] prog_addr,
  output logic              prog_done,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_CLEARING = 2'd0,
    S_RUN      = 2'd1,
    S_LOAD     = 2'd2,
    S_LOADED   = 2'd3
  } state_t;

  state_t              state_q,      state_d;
  logic [ADDR_W-1:0]   clr_ptr_q,    clr_ptr_d;
  logic [ADDR_W-1:0]   prog_addr_q,  prog_addr_d;
  logic [DATA_W-1:0]   ram_output_q, ram_output_d;
  logic                ram_oe_q,     ram_oe_d;
  logic                prog_ready_q, prog_ready_d;
  logic                prog_done_q,  prog_done_d;
  logic                busy_q,       busy_d;

  // Single memory write port shared by the clear sweep and the loader.
  logic                wr_en_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic [DATA_W-1:0]   wr_data_s;
  logic [DATA_W-1:0]   rd_data_s;

  logic [DATA_W-1:0]   mem_q [DEPTH];

  assign rd_data_s = mem_q[mar_input];

  // Next-state, next-output and memory write-port decode for every mode.
  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    prog_addr_d  = prog_addr_q;
    ram_output_d = ram_output_q;
    ram_oe_d     = ram_oe_q;
    prog_ready_d = prog_ready_q;
    prog_done_d  = prog_done_q;
    busy_d       = busy_q;
    wr_en_s      = 1'b0;
    wr_addr_s    = clr_ptr_q;
    wr_data_s    = INIT_VALUE;

    case (state_q)
      S_CLEARING: begin
        // All mode inputs are ignored until the sweep has covered every word.
        wr_en_s      = 1'b1;
        wr_addr_s    = clr_ptr_q;
        wr_data_s    = INIT_VALUE;
        clr_ptr_d    = clr_ptr_q + ONE_ADDR;
        ram_oe_d     = 1'b0;
        prog_ready_d = 1'b0;
        prog_done_d  = 1'b0;
        if (clr_ptr_q == LAST_ADDR) begin
          busy_d = 1'b0;
          if (PROG) begin
            state_d      = S_LOAD;
            prog_addr_d  = ZERO_ADDR;
            prog_ready_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          busy_d = 1'b1;
        end
      end

      S_RUN: begin
        // Program mode wins over a simultaneous read request.
        prog_ready_d = 1'b0;
        prog_done_d  = 1'b0;
        if (PROG) begin
          state_d      = S_LOAD;
          prog_addr_d  = ZERO_ADDR;
          prog_ready_d = 1'b1;
          ram_oe_d     = 1'b0;
        end else if (!CE_bar) begin
          ram_output_d = rd_data_s;
          ram_oe_d     = 1'b1;
        end else begin
          ram_oe_d = 1'b0;
        end
      end

      S_LOAD: begin
        // Abort takes priority over a byte offered on the same edge.
        ram_oe_d = 1'b0;
        if (!PROG) begin
          state_d      = S_RUN;
          prog_ready_d = 1'b0;
        end else if (prog_valid && prog_ready_q) begin
          wr_en_s     = 1'b1;
          wr_addr_s   = prog_addr_q;
          wr_data_s   = prog_data;
          prog_addr_d = prog_addr_q + ONE_ADDR;
          if (prog_addr_q == LAST_ADDR) begin
            state_d      = S_LOADED;
            prog_done_d  = 1'b1;
            prog_ready_d = 1'b0;
          end else begin
            prog_ready_d = 1'b1;
          end
        end else begin
          prog_ready_d = 1'b1;
        end
      end

      S_LOADED: begin
        // Leaving program mode also services a read request on the same
        // edge, so the first byte is available one cycle after PROG drops.
        prog_ready_d = 1'b0;
        if (!PROG) begin
          state_d     = S_RUN;
          prog_done_d = 1'b0;
          if (!CE_bar) begin
            ram_output_d = rd_data_s;
            ram_oe_d     = 1'b1;
          end else begin
            ram_oe_d = 1'b0;
          end
        end else begin
          prog_done_d = 1'b1;
          ram_oe_d    = 1'b0;
        end
      end

      default: begin
        state_d      = S_CLEARING;
        clr_ptr_d    = ZERO_ADDR;
        ram_oe_d     = 1'b0;
        prog_ready_d = 1'b0;
        prog_done_d  = 1'b0;
        busy_d       = 1'b1;
      end
    endcase
  end

  // Control state and registered outputs, with synchronous reset into the sweep.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q      <= S_CLEARING;
      clr_ptr_q    <= ZERO_ADDR;
      prog_addr_q  <= ZERO_ADDR;
      ram_output_q <= {DATA_W{1'b0}};
      ram_oe_q     <= 1'b0;
      prog_ready_q <= 1'b0;
      prog_done_q  <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      prog_addr_q  <= prog_addr_d;
      ram_output_q <= ram_output_d;
      ram_oe_q     <= ram_oe_d;
      prog_ready_q <= prog_ready_d;
      prog_done_q  <= prog_done_d;
      busy_q       <= busy_d;
    end
  end

  // Storage array; not reset directly, the clear sweep initialises it.
  always_ff @(posedge CLK) begin
    if (wr_en_s && !CLR) begin
      mem_q[wr_addr_s] <= wr_data_s;
    end
  end

  assign ram_output = ram_output_q;
  assign ram_oe     = ram_oe_q;
  assign prog_ready = prog_ready_q;
  assign prog_addr  = prog_addr_q;
  assign prog_done  = prog_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ram_16x8.sv
// Self-checking bench for ram_16x8 with a simple array model of the memory.
module tb_ram_16x8;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       PROG;
  logic       CE_bar;
  logic [3:0] mar_input;
  logic [7:0] ram_output;
  logic       ram_oe;
  logic       prog_valid;
  logic [7:0] prog_data;
  logic       prog_ready;
  logic [3:0] prog_addr;
  logic       prog_done;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_mem [16];

  ram_16x8 dut (
    .CLK(CLK), .CLR(CLR), .PROG(PROG), .CE_bar(CE_bar),
    .mar_input(mar_input), .ram_output(ram_output), .ram_oe(ram_oe),
    .prog_valid(prog_valid), .prog_data(prog_data), .prog_ready(prog_ready),
    .prog_addr(prog_addr), .prog_done(prog_done), .busy(busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic exp_busy;
    CLR = 1'b1; PROG = 1'b0; CE_bar = 1'b1; mar_input = 4'd0;
    prog_valid = 1'b0; prog_data = 8'h00;
    step(); step();
    CLR = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b want 1", busy); end
    checks++; if (ram_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %0b want 0", ram_oe); end
    checks++; if (prog_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", prog_ready); end
    checks++; if (prog_addr !== 4'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", prog_addr); end
    checks++; if (prog_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", prog_done); end
    checks++; if (ram_output !== 8'h00) begin errors++; $display("FAIL reset_out got %h want 00", ram_output); end
    // Inputs that must be ignored during the sweep
    PROG = 1'b0; CE_bar = 1'b0; prog_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      exp_busy = (i < 15);
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL clear_busy[%0d] got %0b want %0b", i, busy, exp_busy); end
      checks++; if (prog_ready !== 1'b0) begin errors++; $display("FAIL clear_ready[%0d] got %0b want 0", i, prog_ready); end
      checks++; if (ram_oe !== 1'b0) begin errors++; $display("FAIL clear_oe[%0d] got %0b want 0", i, ram_oe); end
    end
    prog_valid = 1'b0;
    for (int a = 0; a < 16; a++) begin
      mar_input = 4'(a); CE_bar = 1'b0;
      step();
      checks++; if (ram_oe !== 1'b1) begin errors++; $display("FAIL clear_read_oe[%0d] got %0b want 1", a, ram_oe); end
      checks++; if (ram_output !== model_mem[a]) begin errors++; $display("FAIL clear_read[%0d] got %h want %h", a, ram_output, model_mem[a]); end
    end
    CE_bar = 1'b1;
    step();
  endtask

  task automatic test_full_load();
    PROG = 1'b1; CE_bar = 1'b1;
    step();
    checks++; if (prog_ready !== 1'b1) begin errors++; $display("FAIL load_entry_ready got %0b want 1", prog_ready); end
    checks++; if (ram_oe !== 1'b0) begin errors++; $display("FAIL load_entry_oe got %0b want 0", ram_oe); end
    prog_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prog_data = 8'h10 + 8'(i);
      checks++; if (prog_ready !== 1'b1) begin errors++; $display("FAIL load_ready[%0d] got %0b want 1", i, prog_ready); end
      checks++; if (prog_addr !== 4'(i)) begin errors++; $display("FAIL load_addr[%0d] got %0d want %0d", i, prog_addr, i); end
      step();
      model_mem[i] = 8'h10 + 8'(i);
    end
    checks++; if (prog_done !== 1'b1) begin errors++; $display("FAIL load_done got %0b want 1", prog_done); end
    checks++; if (prog_ready !== 1'b0) begin errors++; $display("FAIL load_done_ready got %0b want 0", prog_ready); end
    checks++; if (prog_addr !== 4'd0) begin errors++; $display("FAIL load_wrap_addr got %0d want 0", prog_addr); end
    prog_data = 8'hEE;
    step();
    checks++; if (prog_done !== 1'b1) begin errors++; $display("FAIL loaded_hold_done got %0b want 1", prog_done); end
    prog_valid = 1'b0;
    PROG = 1'b0; mar_input = 4'd5; CE_bar = 1'b0;
    step();
    checks++; if (ram_output !== 8'h15) begin errors++; $display("FAIL exit_read got %h want 15", ram_output); end
    checks++; if (ram_oe !== 1'b1) begin errors++; $display("FAIL exit_oe got %0b want 1", ram_oe); end
    checks++; if (prog_done !== 1'b0) begin errors++; $display("FAIL exit_done got %0b want 0", prog_done); end
    CE_bar = 1'b1;
    step();
    mar_input = 4'd0; CE_bar = 1'b0;
    step();
    checks++; if (ram_output !== model_mem[0]) begin errors++; $display("FAIL loaded_ignored_write got %h want %h", ram_output, model_mem[0]); end
    CE_bar = 1'b1;
    step();
  endtask

  task automatic test_gapped();
    logic       vpat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] dpat [5];
    int ptr = 0;
    dpat[0] = 8'hA0; dpat[1] = 8'($urandom); dpat[2] = 8'($urandom);
    dpat[3] = 8'hA1; dpat[4] = 8'hA2;
    PROG = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      prog_valid = vpat[i]; prog_data = dpat[i];
      step();
      if (vpat[i]) begin model_mem[ptr] = dpat[i]; ptr++; end
    end
    prog_valid = 1'b0;
    checks++; if (prog_addr !== 4'd3) begin errors++; $display("FAIL gap_addr got %0d want 3", prog_addr); end
    PROG = 1'b0;
    step();
    for (int a = 0; a < 4; a++) begin
      mar_input = 4'(a); CE_bar = 1'b0;
      step();
      checks++; if (ram_output !== model_mem[a]) begin errors++; $display("FAIL gap_read[%0d] got %h want %h", a, ram_output, model_mem[a]); end
    end
    CE_bar = 1'b1;
    step();
  endtask

  task automatic test_abort();
    PROG = 1'b1;
    step();
    prog_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prog_data = 8'h10 + 8'(i);
      step();
      model_mem[i] = 8'h10 + 8'(i);
    end
    prog_valid = 1'b0; PROG = 1'b0;
    step();
    PROG = 1'b1;
    step();
    prog_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      prog_data = 8'hC0 + 8'(i);
      step();
      model_mem[i] = 8'hC0 + 8'(i);
    end
    prog_valid = 1'b0;
    step();
    PROG = 1'b0;
    step();
    checks++; if (prog_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %0b want 0", prog_ready); end
    for (int a = 0; a < 4; a++) begin
      mar_input = 4'(a); CE_bar = 1'b0;
      step();
      checks++; if (ram_output !== model_mem[a]) begin errors++; $display("FAIL abort_read[%0d] got %h want %h", a, ram_output, model_mem[a]); end
    end
    CE_bar = 1'b1;
    step();
  endtask

  task automatic test_oe_priority();
    logic [7:0] held;
    mar_input = 4'd4; CE_bar = 1'b0;
    step();
    held = model_mem[4];
    checks++; if (ram_output !== held) begin errors++; $display("FAIL prio_read got %h want %h", ram_output, held); end
    CE_bar = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mar_input = 4'($urandom);
      step();
      checks++; if (ram_oe !== 1'b0) begin errors++; $display("FAIL hold_oe[%0d] got %0b want 0", i, ram_oe); end
      checks++; if (ram_output !== held) begin errors++; $display("FAIL hold_out[%0d] got %h want %h", i, ram_output, held); end
    end
    PROG = 1'b1; CE_bar = 1'b0; mar_input = 4'd9;
    step();
    checks++; if (ram_oe !== 1'b0) begin errors++; $display("FAIL prio_oe got %0b want 0", ram_oe); end
    checks++; if (ram_output !== held) begin errors++; $display("FAIL prio_out got %h want %h", ram_output, held); end
    checks++; if (prog_ready !== 1'b1) begin errors++; $display("FAIL prio_ready got %0b want 1", prog_ready); end
    PROG = 1'b0; CE_bar = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_load();
    logic exp_busy;
    PROG = 1'b1;
    step();
    prog_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      prog_data = 8'($urandom);
      step();
    end
    CLR = 1'b1;
    step();
    CLR = 1'b0; PROG = 1'b0; prog_valid = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    checks++; if (prog_addr !== 4'd0) begin errors++; $display("FAIL mid_addr got %0d want 0", prog_addr); end
    checks++; if (prog_done !== 1'b0) begin errors++; $display("FAIL mid_done got %0b want 0", prog_done); end
    for (int i = 0; i < 16; i++) begin
      step();
      exp_busy = (i < 15);
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL mid_busy[%0d] got %0b want %0b", i, busy, exp_busy); end
    end
    for (int a = 0; a < 16; a++) begin
      mar_input = 4'(a); CE_bar = 1'b0;
      step();
      checks++; if (ram_output !== model_mem[a]) begin errors++; $display("FAIL mid_read[%0d] got %h want %h", a, ram_output, model_mem[a]); end
    end
    CE_bar = 1'b1;
    step();
  endtask

  task automatic test_random();
    int ptr;
    int n;
    int a;
    logic v;
    logic [7:0] d;
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        PROG = 1'b1; CE_bar = 1'b1;
        step();
        ptr = 0;
        n = $urandom_range(1, 30);
        for (int c = 0; c < n; c++) begin
          v = 1'($urandom);
          d = 8'($urandom);
          prog_valid = v; prog_data = d;
          if (ptr < 16) begin
            checks++; if (prog_ready !== 1'b1 || prog_addr !== 4'(ptr)) begin errors++; $display("FAIL rnd_ready it%0d c%0d got ready %0b addr %0d want 1 %0d", it, c, prog_ready, prog_addr, ptr); end
          end else begin
            checks++; if (prog_done !== 1'b1 || prog_ready !== 1'b0) begin errors++; $display("FAIL rnd_done it%0d c%0d got done %0b ready %0b want 1 0", it, c, prog_done, prog_ready); end
          end
          step();
          if (v && ptr < 16) begin model_mem[ptr] = d; ptr++; end
        end
        prog_valid = 1'b0; PROG = 1'b0;
        step();
        checks++; if (prog_ready !== 1'b0 || prog_done !== 1'b0) begin errors++; $display("FAIL rnd_exit it%0d got ready %0b done %0b want 0 0", it, prog_ready, prog_done); end
      end else begin
        for (int r = 0; r < 8; r++) begin
          a = $urandom_range(0, 15);
          mar_input = 4'(a); CE_bar = 1'b0;
          step();
          checks++; if (ram_oe !== 1'b1 || ram_output !== model_mem[a]) begin errors++; $display("FAIL rnd_read it%0d addr %0d got oe %0b %h want 1 %h", it, a, ram_oe, ram_output, model_mem[a]); end
        end
        CE_bar = 1'b1;
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_gapped();
    test_abort();
    test_oe_priority();
    test_reset_mid_load();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
